// File: rtl/seg7_scan_sched_if.sv
// Write-side handshake for the scan scheduler: a 4-digit BCD value offered with valid/ready.
interface seg7_scan_sched_if;
   logic        valid;
   logic [15:0] data;
   logic        ready;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/seg7_scan_sched.sv
// Time-sliced 4-digit 7-segment scan scheduler with per-slot blanking, leading-zero
// suppression and frame-aligned (tear-free) display value updates.
//
// state | meaning
// IDLE  | scan disabled, all digits dark, slot counter parked at digit 0
// BLANK | inside a slot but dark (blanking interval or suppressed leading zero)
// SHOW  | current digit lit
module seg7_scan_sched #(
   parameter int DIV_W     = 16,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   input  logic              lzb_en,
   seg7_scan_sched_if.slave  wr,
   output logic [1:0]        dig_sel,
   output logic [3:0]        an,
   output logic [3:0]        bcd,
   output logic              blank,
   output logic              frame_done
);
   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] CNT_BLK  = DIV_W'(BLANK_CYC);

   state_t            state, state_n;
   logic [DIV_W-1:0]  cnt, cnt_n;
   logic [1:0]        dig_n;
   logic [3:0]        an_n, bcd_n;
   logic              blank_n, fd_n;
   logic [15:0]       shadow, shadow_n, active, active_n;
   logic              pending, pending_n;
   logic              ready_q;
   logic              sup, sup_n;
   logic              slot_start, boundary, accept;

   function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] k);
      logic [3:0] r;
      case (k)
         2'd0:    r = v[3:0];
         2'd1:    r = v[7:4];
         2'd2:    r = v[11:8];
         default: r = v[15:12];
      endcase
      return r;
   endfunction

   // A digit is a leading zero when it and every digit to its left are zero.
   function automatic logic lead_zero(input logic [15:0] v, input logic [1:0] k);
      logic r;
      case (k)
         2'd0:    r = 1'b0;
         2'd1:    r = (v[15:4] == 12'h000);
         2'd2:    r = (v[15:8] == 8'h00);
         default: r = (v[15:12] == 4'h0);
      endcase
      return r;
   endfunction

   assign wr.ready = ready_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= IDLE;
         cnt        <= '0;
         dig_sel    <= 2'd0;
         an         <= 4'b0000;
         bcd        <= 4'h0;
         blank      <= 1'b1;
         frame_done <= 1'b0;
         shadow     <= 16'h0000;
         active     <= 16'h0000;
         pending    <= 1'b0;
         ready_q    <= 1'b1;
         sup        <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         dig_sel    <= dig_n;
         an         <= an_n;
         bcd        <= bcd_n;
         blank      <= blank_n;
         frame_done <= fd_n;
         shadow     <= shadow_n;
         active     <= active_n;
         pending    <= pending_n;
         ready_q    <= ~pending_n;
         sup        <= sup_n;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      dig_n      = dig_sel;
      an_n       = an;
      bcd_n      = bcd;
      blank_n    = blank;
      fd_n       = 1'b0;
      shadow_n   = shadow;
      active_n   = active;
      pending_n  = pending;
      sup_n      = sup;
      slot_start = 1'b0;

      accept   = wr.valid && !pending;
      boundary = en && (state != IDLE) && (cnt == CNT_LAST) && (dig_sel == 2'd3);

      // Apply and accept are exclusive: accept needs pending clear, apply needs it set.
      if (pending && (!en || state == IDLE || boundary)) begin
         active_n  = shadow;
         pending_n = 1'b0;
      end
      if (accept) begin
         shadow_n  = wr.data;
         pending_n = 1'b1;
      end

      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
         dig_n   = 2'd0;
         an_n    = 4'b0000;
         bcd_n   = 4'h0;
         blank_n = 1'b1;
         sup_n   = 1'b0;
      end else begin
         if (state == IDLE) begin
            cnt_n      = '0;
            dig_n      = 2'd0;
            slot_start = 1'b1;
         end else if (cnt == CNT_LAST) begin
            cnt_n      = '0;
            dig_n      = dig_sel + 2'd1;
            slot_start = 1'b1;
         end else begin
            cnt_n = cnt + 1'b1;
         end

         // Suppression is latched once per slot so lzb_en changes never cut a slot short.
         if (slot_start)
            sup_n = lzb_en && lead_zero(active_n, dig_n);

         bcd_n = nibble(active_n, dig_n);
         fd_n  = (cnt_n == CNT_LAST) && (dig_n == 2'd3);

         if (sup_n || (cnt_n < CNT_BLK)) begin
            state_n = BLANK;
            an_n    = 4'b0000;
            blank_n = 1'b1;
         end else begin
            state_n = SHOW;
            an_n    = 4'b0001 << dig_n;
            blank_n = 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_seg7_scan_sched.sv
// Directed bench for seg7_scan_sched at SCAN_DIV=8, BLANK_CYC=2 (32-cycle frames).
module tb_seg7_scan_sched;
   logic       clk = 1'b0;
   logic       clr;
   logic       en;
   logic       lzb_en;
   logic [1:0] dig_sel;
   logic [3:0] an;
   logic [3:0] bcd;
   logic       blank;
   logic       frame_done;

   int n_cmp = 0;
   int n_bad = 0;
   int pos   = 0;

   seg7_scan_sched_if wr_bus ();

   seg7_scan_sched #(.DIV_W(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
      .clk        (clk),
      .clr        (clr),
      .en         (en),
      .lzb_en     (lzb_en),
      .wr         (wr_bus),
      .dig_sel    (dig_sel),
      .an         (an),
      .bcd        (bcd),
      .blank      (blank),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) begin
         @(negedge clk);
         pos = (pos + 1) % 32;
      end
   endtask

   task automatic goto_pos(input int p);
      for (int i = 0; i < 40 && pos != p; i++) adv(1);
   endtask

   task automatic check_show(input string tag, input int p, input logic [3:0] an_exp,
                             input logic [3:0] bcd_exp);
      goto_pos(p);
      chk({tag, "_an"}, {12'h0, an}, {12'h0, an_exp});
      chk({tag, "_bcd"}, {12'h0, bcd}, {12'h0, bcd_exp});
      chk({tag, "_blank"}, {15'h0, blank}, 16'h0000);
   endtask

   task automatic check_dark(input string tag, input int p);
      goto_pos(p);
      chk({tag, "_an"}, {12'h0, an}, 16'h0000);
      chk({tag, "_blank"}, {15'h0, blank}, 16'h0001);
   endtask

   // Loads a value through IDLE; returns at slot 0, cycle 0 with scanning enabled.
   task automatic load_idle(input logic [15:0] d, input logic lz);
      en = 1'b0;
      wr_bus.valid = 1'b1;
      wr_bus.data  = d;
      adv(1);
      chk("ld_ready_low", {15'h0, wr_bus.ready}, 16'h0000);
      chk("ld_idle_an", {12'h0, an}, 16'h0000);
      chk("ld_idle_dig", {14'h0, dig_sel}, 16'h0000);
      wr_bus.valid = 1'b0;
      adv(1);
      chk("ld_ready_high", {15'h0, wr_bus.ready}, 16'h0001);
      en     = 1'b1;
      lzb_en = lz;
      adv(1);
      pos = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clr          = 1'b1;
      en           = 1'b1;
      lzb_en       = 1'b0;
      wr_bus.valid = 1'b0;
      wr_bus.data  = 16'h0000;

      // Reset and first slot
      #12;
      chk("rst_an", {12'h0, an}, 16'h0000);
      chk("rst_blank", {15'h0, blank}, 16'h0001);
      chk("rst_ready", {15'h0, wr_bus.ready}, 16'h0001);
      chk("rst_dig", {14'h0, dig_sel}, 16'h0000);
      chk("rst_fd", {15'h0, frame_done}, 16'h0000);
      chk("rst_bcd", {12'h0, bcd}, 16'h0000);
      @(negedge clk);
      clr = 1'b0;
      adv(1);
      pos = 0;
      check_dark("s0c0", 0);
      chk("s0c0_dig", {14'h0, dig_sel}, 16'h0000);
      check_dark("s0c1", 1);
      check_show("s0c2", 2, 4'b0001, 4'h0);
      check_show("s0c7", 7, 4'b0001, 4'h0);
      check_dark("s1c0", 8);
      chk("s1c0_dig", {14'h0, dig_sel}, 16'h0001);

      // Load 1234 via IDLE, walk one full frame
      load_idle(16'h1234, 1'b0);
      for (int c = 0; c < 32; c++) begin
         if (c > 0) adv(1);
         chk("f1_fd", {15'h0, frame_done}, (c == 31) ? 16'h0001 : 16'h0000);
         case (c)
            2:  check_show("f1_d0", 2, 4'b0001, 4'h4);
            10: check_show("f1_d1", 10, 4'b0010, 4'h3);
            18: check_show("f1_d2", 18, 4'b0100, 4'h2);
            26: check_show("f1_d3", 26, 4'b1000, 4'h1);
            default: ;
         endcase
      end

      // Tear-free update with wr_valid held through a busy period
      goto_pos(10);
      wr_bus.valid = 1'b1;
      wr_bus.data  = 16'h5678;
      adv(1);
      chk("tf_ready_busy", {15'h0, wr_bus.ready}, 16'h0000);
      wr_bus.data = 16'h9999;
      check_show("tf_old_d2", 18, 4'b0100, 4'h2);
      check_show("tf_old_d3", 26, 4'b1000, 4'h1);
      goto_pos(31);
      chk("tf_fd", {15'h0, frame_done}, 16'h0001);
      chk("tf_ready_31", {15'h0, wr_bus.ready}, 16'h0000);
      adv(1);
      chk("tf_ready_0", {15'h0, wr_bus.ready}, 16'h0001);
      adv(1);
      chk("tf_ready_1", {15'h0, wr_bus.ready}, 16'h0000);
      wr_bus.valid = 1'b0;
      check_show("tf_new_d0", 2, 4'b0001, 4'h8);
      check_show("tf_new_d1", 10, 4'b0010, 4'h7);
      check_show("tf_new_d2", 18, 4'b0100, 4'h6);
      check_show("tf_new_d3", 26, 4'b1000, 4'h5);
      adv(1);
      check_show("tf_9_d0", 2, 4'b0001, 4'h9);
      check_show("tf_9_d3", 26, 4'b1000, 4'h9);

      // Leading-zero blanking
      load_idle(16'h0050, 1'b1);
      check_show("lz50_d0", 2, 4'b0001, 4'h0);
      check_show("lz50_d1", 10, 4'b0010, 4'h5);
      check_dark("lz50_d2", 18);
      chk("lz50_d2_bcd", {12'h0, bcd}, 16'h0000);
      check_dark("lz50_d3", 26);
      load_idle(16'h0000, 1'b1);
      check_show("lz00_d0", 2, 4'b0001, 4'h0);
      check_dark("lz00_d1", 10);
      check_dark("lz00_d2", 18);
      check_dark("lz00_d3", 26);

      // Async reset mid-slot with a write pending
      load_idle(16'h1234, 1'b0);
      goto_pos(10);
      wr_bus.valid = 1'b1;
      wr_bus.data  = 16'hABCD;
      adv(1);
      wr_bus.valid = 1'b0;
      chk("ar_ready_busy", {15'h0, wr_bus.ready}, 16'h0000);
      check_show("ar_pre", 19, 4'b0100, 4'h2);
      #2 clr = 1'b1;
      #1;
      chk("ar_an", {12'h0, an}, 16'h0000);
      chk("ar_blank", {15'h0, blank}, 16'h0001);
      chk("ar_dig", {14'h0, dig_sel}, 16'h0000);
      chk("ar_ready", {15'h0, wr_bus.ready}, 16'h0001);
      @(negedge clk);
      clr = 1'b0;
      adv(1);
      pos = 0;
      check_show("ar_d0", 2, 4'b0001, 4'h0);
      chk("ar_ready_after", {15'h0, wr_bus.ready}, 16'h0001);
      check_show("ar_d1", 10, 4'b0010, 4'h0);

      // en drop mid-slot applies the pending write on the same edge
      adv(1);
      goto_pos(10);
      wr_bus.valid = 1'b1;
      wr_bus.data  = 16'hABCD;
      adv(1);
      wr_bus.valid = 1'b0;
      chk("ed_ready_busy", {15'h0, wr_bus.ready}, 16'h0000);
      chk("ed_an_pre", {12'h0, an}, 16'h0002);
      en = 1'b0;
      adv(1);
      chk("ed_an", {12'h0, an}, 16'h0000);
      chk("ed_dig", {14'h0, dig_sel}, 16'h0000);
      chk("ed_blank", {15'h0, blank}, 16'h0001);
      chk("ed_ready", {15'h0, wr_bus.ready}, 16'h0001);
      en = 1'b1;
      adv(1);
      pos = 0;
      check_show("ed_d0", 2, 4'b0001, 4'hD);
      check_show("ed_d1", 10, 4'b0010, 4'hC);
      check_show("ed_d2", 18, 4'b0100, 4'hB);
      check_show("ed_d3", 26, 4'b1000, 4'hA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/seg7_scan_sched.md
Name: seg7_scan_sched

Overview:
- Synchronous scan scheduler for the 4-digit multiplexed 7-segment display path.
- Time-slices one shared BCD-to-7-segment decoder across four digits: selects the digit, drives one-hot anode enables and presents that digit's BCD nibble.
- Inserts a per-slot blanking interval against ghosting and optionally suppresses leading zeros.
- Accepts new 4-digit values through a valid/ready handshake and applies them only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- DIV_W, 16, width of slot cycle counter.
- SCAN_DIV, 50000, clock cycles per digit slot; must be at least 2 and at most 2^DIV_W.
- BLANK_CYC, 500, blanked cycles at start of each slot; must be at least 0 and below SCAN_DIV.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- en  in  1  scan enable.
- lzb_en  in  1  leading-zero blanking enable.
- wr_valid  in  1  new display value offered.
- wr_data  in  16  four nibbles; [15:12] = digit 3 (leftmost), [3:0] = digit 0 (rightmost).
- wr_ready  out  1  scheduler can accept wr_data.
- dig_sel  out  2  index of current digit slot; drives mux select.
- an  out  4  one-hot digit enables, active-high; an[3] = leftmost.
- bcd  out  4  nibble of current digit, to BCD decoder.
- blank  out  1  high when no digit is lit.
- frame_done  out  1  one-cycle pulse on last cycle of digit-3 slot.

Behaviour:
- Reset (clr=1, asynchronous, takes effect immediately):
  - cnt=0, dig_sel=0, an=0000, bcd=0, blank=1, frame_done=0.
  - shadow=0, active=0, pending=0, so wr_ready=1.
- All outputs come from flops. an, bcd and blank reflect the state entered at the same edge that updates cnt and dig_sel.
- State machine states: IDLE, BLANK, SHOW.
- IDLE (en=0):
  - cnt=0, dig_sel=0, an=0000, blank=1.
  - Any pending value moves shadow to active on the next edge.
- en 0 to 1: next edge enters BLANK with dig_sel=0 and cnt=0.
- en 1 to 0: next edge enters IDLE from any state.
- Slot timing: cnt counts 0 to SCAN_DIV-1.
  - cnt < BLANK_CYC: state BLANK, an=0000, blank=1.
  - Otherwise: state SHOW, an=onehot(dig_sel), blank=0, bcd=active[dig_sel].
  - BLANK_CYC=0: no BLANK phase.
- Slot end at cnt=SCAN_DIV-1: cnt wraps to 0, dig_sel increments, 3 wraps to 0.
- Frame boundary is the edge ending the digit-3 slot:
  - frame_done is high during that slot's last cycle.
  - If pending, active takes shadow and pending clears at that edge.
- Handshake:
  - wr_ready = !pending.
  - Transfer occurs when wr_valid and wr_ready are both high at an edge; shadow takes wr_data and pending sets.
  - A write accepted on the frame-boundary edge waits for the following boundary, or the next IDLE edge.
  - wr_valid may stay high while wr_ready=0 without loss of data.
- Leading-zero blanking, active when lzb_en=1:
  - Digit k (k = 3..1) is suppressed if active[k] and every digit above it are 0.
  - Digit 0 is never suppressed.
  - A suppressed slot behaves as BLANK for the whole slot: an=0000, blank=1. bcd still carries the nibble.
- Nibbles A to F are stored and output unchanged.
- en and lzb_en are sampled each edge. lzb_en changes take effect at the next slot's first cycle.

Test Plan:
1. Reset and first slot (SCAN_DIV=8, BLANK_CYC=2): pulse clr, then release with en=1 -> an=0000, blank=1, wr_ready=1 during reset. Slot cycles 0-1: an=0000. Cycles 2-7: an=0001, bcd=0, blank=0.
2. Write 16'h1234 with en=0, then set en=1 -> wr_ready low one cycle, active=1234. Slots show bcd 4/an 0001, 3/0010, 2/0100, 1/1000. frame_done pulses on cycle 31 only.
3. Tear-free update: during digit-1 SHOW of a frame showing 1234, write 16'h5678, then hold wr_valid with 16'h9999 -> rest of frame shows 2 then 1. Next frame shows 8,7,6,5. 9999 is accepted on the edge after that boundary (wr_ready=1) and appears the frame after.
4. LZB: lzb_en=1, active=16'h0050 -> digit-3 and digit-2 slots have an=0000, blank=1. Digit 1 shows 5, digit 0 shows 0. With active=16'h0000, only the digit-0 slot lights (an=0001, bcd=0).
5. Async reset mid-slot: assert clr between edges during digit-2 SHOW -> an=0000, blank=1 immediately. After release, active=0, wr_ready=1, dig_sel=0.
6. en drop mid-slot: en=0 during digit-1 SHOW -> next edge an=0000, dig_sel=0, blank=1. A pending write is applied on that same edge.
